// File: rtl/button_ctrl.sv
// button_ctrl: synchronise, debounce and classify N_BTN push buttons, then
// arbitrate press/release/long events round-robin onto one valid/ready stream.
module button_ctrl #(
   parameter int N_BTN      = 4,
   parameter int CLK_DIV    = 1000,
   parameter int DEB_TICKS  = 20,
   parameter int LONG_TICKS = 500
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_BTN-1:0]         btn_i,
   output logic [N_BTN-1:0]         stable_o,
   output logic                     evt_valid_o,
   input  logic                     evt_ready_i,
   output logic [$clog2(N_BTN)-1:0] evt_id_o,
   output logic [1:0]               evt_code_o,
   output logic                     drop_o
);
   localparam int IW = $clog2(N_BTN);
   localparam int CW = $clog2(CLK_DIV);
   localparam int DW = $clog2(DEB_TICKS) + 1;
   localparam int HW = $clog2(LONG_TICKS) + 1;

   logic [N_BTN-1:0]          r_sync1, r_sync2, r_stable;
   logic [CW-1:0]             r_div;
   logic [N_BTN-1:0][DW-1:0]  r_deb;
   logic [N_BTN-1:0][HW-1:0]  r_hold;
   logic [N_BTN-1:0][1:0]     r_slot;
   logic                      r_valid, r_drop;
   logic [IW-1:0]             r_id, r_ptr;
   logic [1:0]                r_code;

   logic                      w_tick, w_load, w_found, w_drop;
   logic [IW-1:0]             w_gid;
   logic [N_BTN-1:0][1:0]     w_evt;
   logic [N_BTN-1:0]          w_take;

   always_comb begin
      w_tick  = r_div == CW'(CLK_DIV - 1);
      w_load  = !r_valid || evt_ready_i;
      w_found = 1'b0;
      w_gid   = '0;
      // scan farthest-first so the nearest index after the last grant wins
      for (int k = N_BTN; k >= 1; k--)
         if (r_slot[IW'((int'(r_ptr) + k) % N_BTN)] != 2'b00) begin
            w_found = 1'b1;
            w_gid   = IW'((int'(r_ptr) + k) % N_BTN);
         end
      w_drop = 1'b0;
      w_evt  = '0;
      w_take = '0;
      for (int i = 0; i < N_BTN; i++) begin
         w_take[i] = w_load && w_found && w_gid == IW'(i);
         w_evt[i]  = (w_tick && r_sync2[i] != r_stable[i] && r_deb[i] == DW'(DEB_TICKS - 1)) ? (r_stable[i] ? 2'b10 : 2'b01) :
                     (w_tick && r_stable[i] && r_hold[i] == HW'(LONG_TICKS - 1)) ? 2'b11 : 2'b00;
         w_drop    = w_drop | (w_evt[i] != 2'b00 && r_slot[i] != 2'b00 && !w_take[i]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_div    <= '0;
         r_deb    <= '0;
         r_hold   <= '0;
         r_slot   <= '0;
      end else begin
         r_sync1 <= btn_i;
         r_sync2 <= r_sync1;
         r_div   <= w_tick ? '0 : r_div + 1'b1;
         for (int i = 0; i < N_BTN; i++) begin
            if (w_tick) begin
               if (r_sync2[i] == r_stable[i])
                  r_deb[i] <= '0;
               else if (r_deb[i] == DW'(DEB_TICKS - 1)) begin
                  r_deb[i]    <= '0;
                  r_stable[i] <= ~r_stable[i];
               end else
                  r_deb[i] <= r_deb[i] + 1'b1;
            end
            if (!r_stable[i])
               r_hold[i] <= '0;
            else if (w_tick && r_hold[i] != HW'(LONG_TICKS))
               r_hold[i] <= r_hold[i] + 1'b1;
            // a fresh event always wins over the slot being drained
            if (w_evt[i] != 2'b00)
               r_slot[i] <= w_evt[i];
            else if (w_take[i])
               r_slot[i] <= 2'b00;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_id    <= '0;
         r_code  <= 2'b00;
         r_ptr   <= IW'(N_BTN - 1);
         r_drop  <= 1'b0;
      end else begin
         r_drop <= w_drop;
         if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
               r_id   <= w_gid;
               r_code <= r_slot[w_gid];
               r_ptr  <= w_gid;
            end
         end
      end
   end

   assign stable_o    = r_stable;
   assign evt_valid_o = r_valid;
   assign evt_id_o    = r_id;
   assign evt_code_o  = r_code;
   assign drop_o      = r_drop;
endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed scenarios for button_ctrl with small timing parameters.
module tb_button_ctrl;
   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [3:0] btn = 4'b0000;
   logic       ready = 1'b1;
   logic [3:0] stable_o;
   logic       evt_valid_o;
   logic [1:0] evt_id_o;
   logic [1:0] evt_code_o;
   logic       drop_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_drop = 0;
   logic [3:0] q[$];
   int stamp[$];

   button_ctrl #(.N_BTN(4), .CLK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(5)) dut (
      .clk_i(clk), .rst_i(rst_i), .btn_i(btn), .stable_o(stable_o),
      .evt_valid_o(evt_valid_o), .evt_ready_i(ready), .evt_id_o(evt_id_o),
      .evt_code_o(evt_code_o), .drop_o(drop_o)
   );

   always #5 clk = ~clk;

   // transfers and drop pulses, taken from pre-edge values
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_i) begin
         if (evt_valid_o && ready) begin
            q.push_back({evt_id_o, evt_code_o});
            stamp.push_back(cyc);
         end
         if (drop_o) n_drop++;
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_q(input int n, input int budget, input string name);
      int t = 0;
      while (q.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (q.size() < n) begin
         errors++;
         $display("FAIL %s timeout: events=%0d required=%0d", name, q.size(), n);
      end
   endtask

   task automatic wait_stable(input int b, input logic lvl, input int budget, output int t);
      t = 0;
      while (stable_o[b] !== lvl && t < budget) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      btn   = 4'b0000;
      ready = 1'b1;
      wait_n(3);
      rst_i = 1'b0;
      q.delete();
      stamp.delete();
      n_drop = 0;
   endtask

   task automatic test_reset();
      wait_n(3);
      checks++;
      if ({stable_o, evt_valid_o, evt_id_o, evt_code_o, drop_o} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 0", {stable_o, evt_valid_o, evt_id_o, evt_code_o, drop_o});
      end
      apply_reset();
   endtask

   task automatic test_press();
      int t;
      q.delete();
      btn[1] = 1'b1;
      wait_stable(1, 1'b1, 20, t);
      checks++;
      if (stable_o[1] !== 1'b1) begin errors++; $display("FAIL press_stable: got %b after %0d cycles required 1", stable_o[1], t); end
      checks++;
      if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL press_early_valid: got %b required 0", evt_valid_o); end
      @(negedge clk);
      checks++;
      if ({evt_valid_o, evt_id_o, evt_code_o} !== 5'b1_01_01) begin
         errors++;
         $display("FAIL press_evt: got %b required 10101", {evt_valid_o, evt_id_o, evt_code_o});
      end
      btn[1] = 1'b0;
      wait_stable(1, 1'b0, 24, t);
      checks++;
      if (stable_o[1] !== 1'b0) begin errors++; $display("FAIL release_stable: got %b required 0", stable_o[1]); end
      wait_q(2, 6, "press_release");
      wait_n(10);
      checks++;
      if (!(q.size() == 2 && q[0] == 4'b0101 && q[1] == 4'b0110)) begin
         errors++;
         $display("FAIL press_seq: got %p required '{5,6}", q);
      end
   endtask

   task automatic test_glitch();
      logic ok = 1'b1;
      q.delete();
      btn[2] = 1'b1;
      wait_n(8);
      btn[2] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (stable_o[2] !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL glitch_stable: got 1 required 0"); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d required 0", q.size()); end
   endtask

   task automatic test_long();
      int t;
      int t2 = 0;
      q.delete();
      btn[0] = 1'b1;
      wait_stable(0, 1'b1, 20, t);
      checks++;
      if (stable_o[0] !== 1'b1) begin errors++; $display("FAIL long_stable: got %b required 1", stable_o[0]); end
      while (!(evt_valid_o === 1'b1 && evt_code_o === 2'b11) && t2 < 40) begin
         @(negedge clk);
         t2++;
      end
      checks++;
      if (t2 != 21 || evt_id_o !== 2'd0) begin
         errors++;
         $display("FAIL long_timing: got %0d cycles id %0d required 21 id 0", t2, evt_id_o);
      end
      wait_n(40);
      checks++;
      if (!(q.size() == 2 && q[0] == 4'b0001 && q[1] == 4'b0011)) begin
         errors++;
         $display("FAIL long_seq: got %p required '{1,3}", q);
      end
      btn[0] = 1'b0;
      wait_stable(0, 1'b0, 24, t);
      wait_n(40);
      checks++;
      if (!(q.size() == 3 && q[2] == 4'b0010)) begin
         errors++;
         $display("FAIL long_release: got %p required '{1,3,2}", q);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      btn = 4'b1111;
      wait_q(4, 40, "simul_press");
      btn = 4'b0000;
      checks++;
      if (!(q.size() >= 4 && q[0] == 4'b0001 && q[1] == 4'b0101 && q[2] == 4'b1001 && q[3] == 4'b1101)) begin
         errors++;
         $display("FAIL simul_order: got %p required '{1,5,9,13}", q);
      end
      checks++;
      if (!(stamp.size() >= 4 && stamp[1] == stamp[0] + 1 && stamp[2] == stamp[0] + 2 && stamp[3] == stamp[0] + 3)) begin
         errors++;
         $display("FAIL simul_b2b: got stamps %p required consecutive", stamp);
      end
      wait_q(8, 40, "simul_release");
      checks++;
      if (!(q.size() == 8 && q[4] == 4'b0010 && q[5] == 4'b0110 && q[6] == 4'b1010 && q[7] == 4'b1110)) begin
         errors++;
         $display("FAIL simul_release: got %p required releases 0..3", q);
      end
   endtask

   task automatic test_rr();
      q.delete();
      btn[0] = 1'b1;
      wait_q(1, 40, "rr_first");
      btn = 4'b0010;
      wait_q(3, 40, "rr_pair");
      btn = 4'b0000;
      checks++;
      if (!(q.size() >= 3 && q[0] == 4'b0001 && q[1] == 4'b0101 && q[2] == 4'b0010)) begin
         errors++;
         $display("FAIL rr_order: got %p required '{1,5,2}", q);
      end
      wait_q(4, 40, "rr_release");
      checks++;
      if (!(q.size() == 4 && q[3] == 4'b0110)) begin
         errors++;
         $display("FAIL rr_release: got %p required last 6", q);
      end
   endtask

   task automatic test_backpressure();
      int t;
      logic held = 1'b1;
      ready = 1'b0;
      q.delete();
      n_drop = 0;
      btn[1] = 1'b1;
      wait_stable(1, 1'b1, 20, t);
      btn[1] = 1'b0;
      @(negedge clk);
      checks++;
      if ({evt_valid_o, evt_id_o, evt_code_o} !== 5'b1_01_01) begin
         errors++;
         $display("FAIL bp_first: got %b required 10101", {evt_valid_o, evt_id_o, evt_code_o});
      end
      t = 0;
      while (stable_o[1] !== 1'b0 && t < 30) begin
         @(negedge clk);
         t++;
         if ({evt_valid_o, evt_id_o, evt_code_o} !== 5'b1_01_01) held = 1'b0;
      end
      btn[1] = 1'b1;
      checks++;
      if (n_drop != 0) begin errors++; $display("FAIL bp_no_drop: got %0d required 0", n_drop); end
      t = 0;
      while (stable_o[1] !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
         if ({evt_valid_o, evt_id_o, evt_code_o} !== 5'b1_01_01) held = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if ({evt_valid_o, evt_id_o, evt_code_o} !== 5'b1_01_01) held = 1'b0;
      end
      checks++;
      if (!held) begin errors++; $display("FAIL bp_hold: output changed while stalled"); end
      checks++;
      if (n_drop != 1) begin errors++; $display("FAIL bp_drop: got %0d required 1", n_drop); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL bp_stall: got %0d transfers required 0", q.size()); end
      ready = 1'b1;
      wait_q(2, 10, "bp_drain");
      btn[1] = 1'b0;
      wait_q(3, 40, "bp_release");
      checks++;
      if (!(q.size() == 3 && q[0] == 4'b0101 && q[1] == 4'b0101 && q[2] == 4'b0110 && n_drop == 1)) begin
         errors++;
         $display("FAIL bp_seq: got %p drops %0d required '{5,5,6} drops 1", q, n_drop);
      end
   endtask

   task automatic test_async_reset();
      int t = 0;
      ready = 1'b0;
      q.delete();
      btn[0] = 1'b1;
      while (evt_valid_o !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL ar_setup: valid %b required 1", evt_valid_o); end
      btn[2] = 1'b1;
      wait_n(6);
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if ({stable_o, evt_valid_o, evt_id_o, evt_code_o, drop_o} !== 10'b0) begin
         errors++;
         $display("FAIL ar_immediate: got %b required 0", {stable_o, evt_valid_o, evt_id_o, evt_code_o, drop_o});
      end
      btn[0] = 1'b0;
      wait_n(3);
      rst_i = 1'b0;
      ready = 1'b1;
      q.delete();
      t = 0;
      while (stable_o[2] !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t != 12) begin errors++; $display("FAIL ar_debounce: got %0d cycles required 12", t); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL ar_stale: got %p required none", q); end
      wait_q(1, 5, "ar_press");
      checks++;
      if (!(q.size() == 1 && q[0] == 4'b1001)) begin
         errors++;
         $display("FAIL ar_evt: got %p required '{9}", q);
      end
      btn[2] = 1'b0;
      wait_q(2, 40, "ar_release");
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_long();
      test_simultaneous();
      test_rr();
      test_backpressure();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
